// File: rtl/sram_bram_responder_if.sv
// SRAM request bus: initiator drives req/rd/addr/be/wr_data and the responder returns ready, read data and the out-of-range flag.
// Transfers happen on a clock edge where sram_req && sram_ready; read data arrives later with a single-cycle sram_rd_data_vld pulse.
interface sram_bram_responder_if;
  logic        sram_req;
  logic        sram_ready;
  logic        sram_rd;
  logic [17:0] sram_addr;
  logic [1:0]  sram_be;
  logic [15:0] sram_wr_data;
  logic        sram_rd_data_vld;
  logic [15:0] sram_rd_data;
  logic        err_oob;

  modport master (
    output sram_req, sram_rd, sram_addr, sram_be, sram_wr_data,
    input  sram_ready, sram_rd_data_vld, sram_rd_data, err_oob
  );

  modport slave (
    input  sram_req, sram_rd, sram_addr, sram_be, sram_wr_data,
    output sram_ready, sram_rd_data_vld, sram_rd_data, err_oob
  );
endinterface

// File: rtl/sram_bram_responder.sv
// Block-RAM stand-in for the external SRAM; reads return RD_LATENCY cycles after acceptance, in order.
// sram_ready stays high after reset unless SRAM_EMU_WAIT_EN is defined, which drops it for WAIT_CYCLES cycles per access.
module sram_bram_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int RD_LATENCY  = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_bram_responder_if.slave  bus
);

  localparam int          DEPTH   = 1 << ADDR_BITS;
  localparam logic [15:0] OOB_DAT = 16'hDEAD;

  if (ADDR_BITS < 8 || ADDR_BITS > 14 || RD_LATENCY < 1 || RD_LATENCY > 4 ||
      WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_bad_param
    $error("sram_bram_responder: parameter out of legal range");
  end

  logic [15:0]           mem [DEPTH];
  logic                  ready_q, ready_d;
  logic                  err_oob_q, err_oob_d;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [15:0]           pipe_dat_q [RD_LATENCY];
  logic [15:0]           pipe_dat_d [RD_LATENCY];

  logic                  accept;
  logic                  oob;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [ADDR_BITS-1:0]  idx;

  assign accept = bus.sram_req && ready_q;
  assign oob    = |bus.sram_addr[17:ADDR_BITS];
  assign idx    = bus.sram_addr[ADDR_BITS-1:0];
  assign rd_acc = accept && bus.sram_rd;
  assign wr_acc = accept && !bus.sram_rd && !oob;

  // Array is never reset so it maps onto block RAM and survives a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_acc && bus.sram_be[0]) mem[idx][7:0]  <= bus.sram_wr_data[7:0];
    if (wr_acc && bus.sram_be[1]) mem[idx][15:8] <= bus.sram_wr_data[15:8];
  end

  always_comb begin
    pipe_vld_d    = '0;
    pipe_vld_d[0] = rd_acc;
    for (int k = 0; k < RD_LATENCY; k++) pipe_dat_d[k] = pipe_dat_q[k];
    if (rd_acc) pipe_dat_d[0] = oob ? OOB_DAT : mem[idx];
    // Data only advances behind a valid bit, so the last stage holds between pulses.
    for (int k = 1; k < RD_LATENCY; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      if (pipe_vld_q[k-1]) pipe_dat_d[k] = pipe_dat_q[k-1];
    end
    err_oob_d = err_oob_q | (accept && oob);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld_q <= '0;
      for (int k = 0; k < RD_LATENCY; k++) pipe_dat_q[k] <= '0;
      err_oob_q  <= 1'b0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      for (int k = 0; k < RD_LATENCY; k++) pipe_dat_q[k] <= pipe_dat_d[k];
      err_oob_q  <= err_oob_d;
    end
  end

`ifdef SRAM_EMU_WAIT_EN
  typedef enum logic {ST_READY, ST_WAIT} state_e;

  localparam logic [2:0] WAIT_LOAD = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      ST_READY: begin
        if (accept && WAIT_CYCLES > 0) begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_LOAD;
          ready_d = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_READY;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_READY;
      cnt_q   <= 3'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end
`else
  assign ready_d = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_q <= 1'b0;
    else       ready_q <= ready_d;
  end
`endif

  assign bus.sram_ready       = ready_q;
  assign bus.sram_rd_data_vld = pipe_vld_q[RD_LATENCY-1];
  assign bus.sram_rd_data     = pipe_dat_q[RD_LATENCY-1];
  assign bus.err_oob          = err_oob_q;

endmodule

// File: tb/tb_sram_bram_responder.sv
// Randomized bench for sram_bram_responder against a queue/array reference model, with directed literal checks.
module tb_sram_bram_responder;
  localparam int ADDR_BITS   = 12;
  localparam int RD_LATENCY  = 2;
  localparam int WAIT_CYCLES = 3;
`ifdef SRAM_EMU_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam int EXP_GAP = (WAIT_EN && WAIT_CYCLES > 0) ? WAIT_CYCLES + 1 : 1;

  logic clk = 1'b0;
  logic reset = 1'b0;

  sram_bram_responder_if bus();

  sram_bram_responder #(
    .ADDR_BITS(ADDR_BITS), .RD_LATENCY(RD_LATENCY), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: responses are a queue of (due cycle, data); memory is a plain array.
  typedef struct { int due; logic [15:0] d; } rsp_t;
  rsp_t                 rq[$];
  logic [15:0]          mdl_mem [1 << ADDR_BITS];
  int                   cyc = 0;
  int                   busy = 0;
  bit                   m_ready = 1'b0;
  bit                   e_vld = 1'b0;
  logic [15:0]          e_dat = 16'h0;
  bit                   e_oob = 1'b0;
  bit                   m_acc;
  bit                   m_oob;
  logic [ADDR_BITS-1:0] m_a;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready = 1'b0; busy = 0; e_vld = 1'b0; e_dat = 16'h0; e_oob = 1'b0;
      rq.delete();
    end else begin
      cyc++;
      m_acc = bus.sram_req && m_ready;
      m_oob = (bus.sram_addr[17:ADDR_BITS] != '0);
      m_a   = bus.sram_addr[ADDR_BITS-1:0];
      if (m_acc && bus.sram_rd)
        rq.push_back('{due: cyc + RD_LATENCY - 1, d: (m_oob ? 16'hDEAD : mdl_mem[m_a])});
      if (m_acc && !bus.sram_rd && !m_oob) begin
        if (bus.sram_be[0]) mdl_mem[m_a][7:0]  = bus.sram_wr_data[7:0];
        if (bus.sram_be[1]) mdl_mem[m_a][15:8] = bus.sram_wr_data[15:8];
      end
      if (m_acc && m_oob) e_oob = 1'b1;
      if (WAIT_EN && WAIT_CYCLES > 0) begin
        if (m_acc) busy = WAIT_CYCLES;
        else if (busy > 0) busy--;
        m_ready = (busy == 0);
      end else begin
        m_ready = 1'b1;
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e_vld = 1'b1;
        e_dat = rq[0].d;
        void'(rq.pop_front());
      end else begin
        e_vld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("ready",   bus.sram_ready,       m_ready);
    chk("vld",     bus.sram_rd_data_vld, e_vld);
    chk("rd_data", bus.sram_rd_data,     e_dat);
    chk("err_oob", bus.err_oob,          e_oob);
    if (bus.sram_rd_data_vld === 1'b1) pulses++;
  end

  // Leaves sram_req high on return so consecutive calls stream back-to-back.
  task automatic access(input bit rd, input logic [17:0] addr, input logic [1:0] be,
                        input logic [15:0] d, output int acc_cyc);
    int t;
    t = 0;
    acc_cyc = -1;
    bus.sram_req = 1'b1; bus.sram_rd = rd; bus.sram_addr = addr;
    bus.sram_be = be; bus.sram_wr_data = d;
    while (acc_cyc < 0 && t < 50) begin
      @(negedge clk);
      if (bus.sram_ready === 1'b1) begin
        @(posedge clk); #1;
        acc_cyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
      t++;
    end
    if (acc_cyc < 0) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no acceptance expected one within 50 cycles at %0t", $time);
      bus.sram_req = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    bus.sram_req = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic read_check(input logic [17:0] addr, input logic [15:0] exp, input string name);
    int  ac;
    int  n;
    bit  got;
    n = 0;
    got = 1'b0;
    access(1'b1, addr, 2'b11, 16'h0, ac);
    bus.sram_req = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (bus.sram_rd_data_vld === 1'b1) begin
        got = 1'b1;
        chk({name, "_lat"}, n, RD_LATENCY);
        chk({name, "_dat"}, bus.sram_rd_data, exp);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no read pulse expected one within 10 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int ac, prev, p0;
    logic [17:0] ra;
    bus.sram_req = 1'b0; bus.sram_rd = 1'b0; bus.sram_addr = '0;
    bus.sram_be = 2'b00; bus.sram_wr_data = '0;
    #3 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.sram_ready, 0);
    chk("rst_vld",   bus.sram_rd_data_vld, 0);
    chk("rst_dat",   bus.sram_rd_data, 0);
    chk("rst_oob",   bus.err_oob, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", bus.sram_ready, 1);

    for (int i = 0; i < 64; i++) access(1'b0, 18'(i), 2'b11, 16'($urandom), ac);
    idle(1);

    // Write immediately followed by read of the same word.
    access(1'b0, 18'h00005, 2'b11, 16'h1234, ac);
    read_check(18'h00005, 16'h1234, "basic");

    access(1'b0, 18'h00005, 2'b11, 16'hAAAA, ac);
    access(1'b0, 18'h00005, 2'b01, 16'h5555, ac);
    read_check(18'h00005, 16'hAA55, "be01");
    access(1'b0, 18'h00005, 2'b00, 16'hFFFF, ac);
    read_check(18'h00005, 16'hAA55, "be00");
    access(1'b0, 18'h00006, 2'b10, 16'h12FF, ac);
    access(1'b0, 18'h00006, 2'b01, 16'hEE34, ac);
    read_check(18'h00006, 16'h1234, "be10");

    p0 = pulses;
    prev = -1;
    for (int i = 0; i < 16; i++) begin
      access(1'b1, 18'(16 + i), 2'b11, 16'h0, ac);
      if (prev >= 0) chk("stream_gap", ac - prev, EXP_GAP);
      prev = ac;
    end
    idle(8);
    chk("stream_pulses", pulses - p0, 16);

    access(1'b0, 18'h00000, 2'b11, 16'h0BEE, ac);
    access(1'b0, 18'h01000, 2'b11, 16'h7777, ac);
    read_check(18'h01000, 16'hDEAD, "oob_rd");
    chk("oob_flag", bus.err_oob, 1);
    read_check(18'h00000, 16'h0BEE, "oob_addr0");
    chk("oob_sticky", bus.err_oob, 1);

    prev = -1;
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 18'(48 + i), 2'b11, 16'($urandom), ac);
      if (prev >= 0) chk("wait_gap", ac - prev, EXP_GAP);
      prev = ac;
    end
    idle(2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) ra = {6'($urandom_range(1, 63)), 12'($urandom)};
      else ra = 18'($urandom_range(0, 63));
      access(1'($urandom_range(0, 1)), ra, 2'($urandom), 16'($urandom), ac);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
    end
    idle(8);

    // Reset lands between acceptance and the response edge.
    access(1'b0, 18'h00020, 2'b11, 16'h3C3C, ac);
    access(1'b1, 18'h00021, 2'b11, 16'h0, ac);
    bus.sram_req = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    p0 = pulses;
    repeat (3) @(negedge clk);
    chk("rst_mid_pulses", pulses - p0, 0);
    chk("rst_mid_ready",  bus.sram_ready, 0);
    chk("rst_mid_dat",    bus.sram_rd_data, 0);
    chk("rst_mid_oob",    bus.err_oob, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    read_check(18'h00020, 16'h3C3C, "post_rst");
    chk("post_rst_oob", bus.err_oob, 0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_bram_responder.md
# sram_bram_responder

On-chip responder for the SRAM request interface (`sram_req`/`sram_ready` handshake, 18-bit word address, 16-bit data, 2-bit byte enable). It serves accesses from an on-chip block-RAM array instead of the external 256K×16 SRAM, so a request initiator such as the RAM tester can run, and be verified, without the board SRAM. It drops in wherever the external SRAM controller sits, port-for-port on the request side. It has a programmable read latency and optional wait-state insertion.

## Interface
- `ADDR_BITS`, default 12: implemented word-address width; depth = 2^ADDR_BITS words; legal range 8..14.
- `RD_LATENCY`, default 2: cycles from read acceptance to `sram_rd_data_vld`; legal range 1..4.
- `WAIT_CYCLES`, default 1: idle cycles forced after each accepted access (used only with `SRAM_EMU_WAIT_EN`); legal range 0..7.
- `clk`  in  1  single design clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sram_req`  in  1  initiator requests an access.
- `sram_ready`  out  1  responder can accept; a transfer occurs on an edge where `sram_req && sram_ready`.
- `sram_rd`  in  1  1 = read, 0 = write; sampled at acceptance.
- `sram_addr`  in  18  word address; sampled at acceptance.
- `sram_be`  in  2  byte enables for writes; bit0 = [7:0], bit1 = [15:8].
- `sram_wr_data`  in  16  write data; sampled at acceptance.
- `sram_rd_data_vld`  out  1  single-cycle pulse qualifying `sram_rd_data`.
- `sram_rd_data`  out  16  read data.
- `err_oob`  out  1  sticky flag: an access with an address beyond the implemented depth was accepted.

## Operation
- Accept on a rising edge with `sram_req && sram_ready`. Address, direction, byte enables and data are captured on that edge only.
- Write: update only the bytes whose `sram_be` bit is 1. `sram_be = 2'b00` is accepted as a no-op. No response pulse.
- Read: `sram_be` is ignored and the full word is returned. Each accepted read yields exactly one `sram_rd_data_vld` pulse. Responses are returned in acceptance order.
- Read pipeline: a RD_LATENCY-deep shift register of {valid, data}. Back-to-back reads, one per cycle, produce back-to-back valid pulses.
- Out of range (`sram_addr[17:ADDR_BITS] != 0`):
  - Write: dropped, array unchanged.
  - Read: returns 16'hDEAD with normal latency.
  - In both cases `err_oob` is set to 1 and holds until `reset`.
- Read-after-write: a write accepted at edge N followed by a read of the same address accepted at edge N+1 returns the new data.
- Reset (asynchronous, any time):
  - `sram_ready` = 0, `sram_rd_data_vld` = 0, `sram_rd_data` = 0, `err_oob` = 0.
  - Reads in flight are discarded with no pulse.
  - Array contents are not cleared.
- Wait-state FSM (used only with `SRAM_EMU_WAIT_EN`), states READY and WAIT:
  - READY → WAIT on acceptance when WAIT_CYCLES > 0. The counter loads WAIT_CYCLES−1.
  - WAIT → READY when the counter reaches 0.
  - `sram_ready` = 1 only in READY.

## Timing
- `sram_ready` is registered: it is 0 during reset and goes to 1 on the first rising edge after `reset` deasserts.
- Read accepted at edge N: `sram_rd_data_vld` = 1 and data valid during the cycle after edge N+RD_LATENCY−1, i.e. sampled by the initiator at edge N+RD_LATENCY.
- `sram_rd_data` holds its last value between pulses.
- Without wait states, sustained throughput is one access per cycle.
- With wait states (WAIT_CYCLES = W > 0), accepted accesses are spaced W+1 cycles apart.
- `err_oob` rises in the cycle after the offending acceptance edge.

## Configuration
- `SRAM_EMU_WAIT_EN`:
  - Defined: the wait-state FSM is built and `sram_ready` drops for WAIT_CYCLES cycles after every acceptance, to exercise initiator backpressure handling.
  - Undefined: no FSM is built, `sram_ready` stays at 1 after reset, and `WAIT_CYCLES` is ignored.

## Test plan
- Basic write/read: write 0x1234 to address 0x005 (be = 11), then read 0x005 → one pulse after exactly RD_LATENCY cycles with data 0x1234.
- Byte enables: write 0xAAAA (be = 11), then write 0x5555 (be = 01), then read → 0xAA55. A write with be = 00 leaves 0xAA55 unchanged.
- Streaming: 16 consecutive reads with `sram_req` held high, no wait states → 16 consecutive pulses, data in address order, first pulse RD_LATENCY cycles after the first acceptance.
- Out of range: with ADDR_BITS = 12, write then read 0x01000 → read returns 0xDEAD, `err_oob` = 1 and stays set. The contents of address 0x000 are unchanged.
- Wait states: with `SRAM_EMU_WAIT_EN` defined and WAIT_CYCLES = 3, hold `sram_req` high for 4 writes → acceptances 4 cycles apart and `sram_ready` low for exactly 3 cycles after each.
- Reset mid-read: assert `reset` one cycle after a read is accepted → no `sram_rd_data_vld` pulse, all outputs 0 during reset. After release, data written before reset reads back intact.
